// File: rtl/meta_write_rr_arbiter.sv
// ---------------------------------------------------------------------------
// meta_write_rr_arbiter
//
// N-way arbiter for data-cache metadata write requests (idx / way_en / tag).
// One requester is granted per cycle, by fixed priority (lowest index wins)
// or round-robin. The winner's payload is pushed into a small registered
// FIFO that feeds the metadata array write port. Because the output side is
// registered, io_out_ready has no combinational path to any io_in_ready.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. Ready never depends on io_out_ready. A requester may drop
// valid without a transfer. Its payload is sampled only in its own transfer
// cycle. The FIFO head is held stable while io_out_valid is high and
// io_out_ready is low.
//
// Ports:
//   clock              in   sole clock, rising edge
//   reset              in   asynchronous, active-low reset
//   io_in_valid        in   [N_IN]        per-requester valid
//   io_in_ready        out  [N_IN]        per-requester ready (at most one high)
//   io_in_bits_idx     in   [N_IN*IDX_W]  requester i at [i*IDX_W +: IDX_W]
//   io_in_bits_way_en  in   [N_IN*WAY_W]  same packing
//   io_in_bits_tag     in   [N_IN*TAG_W]  same packing
//   io_out_valid       out  FIFO head valid
//   io_out_ready       in   metadata array accepts the head
//   io_out_bits_idx    out  head idx
//   io_out_bits_way_en out  head way_en
//   io_out_bits_tag    out  head tag
//   io_out_bits_src    out  index of the requester that produced the head
//   io_count           out  current FIFO occupancy
// ---------------------------------------------------------------------------
module meta_write_rr_arbiter #(
    parameter int N_IN    = 8,
    parameter int IDX_W   = 6,
    parameter int WAY_W   = 8,
    parameter int TAG_W   = 20,
    parameter int RR_MODE = 1,
    parameter int DEPTH   = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [N_IN-1:0]              io_in_valid,
    output logic [N_IN-1:0]              io_in_ready,
    input  logic [N_IN*IDX_W-1:0]        io_in_bits_idx,
    input  logic [N_IN*WAY_W-1:0]        io_in_bits_way_en,
    input  logic [N_IN*TAG_W-1:0]        io_in_bits_tag,
    output logic                         io_out_valid,
    input  logic                         io_out_ready,
    output logic [IDX_W-1:0]             io_out_bits_idx,
    output logic [WAY_W-1:0]             io_out_bits_way_en,
    output logic [TAG_W-1:0]             io_out_bits_tag,
    output logic [$clog2(N_IN)-1:0]      io_out_bits_src,
    output logic [$clog2(DEPTH+1)-1:0]   io_count
);

    localparam int SRC_W = $clog2(N_IN);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = SRC_W + TAG_W + WAY_W + IDX_W;

    // FIFO entry layout: {src, tag, way_en, idx}
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             space;
    logic             fire_in;
    logic             fire_out;
    logic             grant_any;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Space comes from the registered count only, so a full FIFO refuses
    // enqueue even in a cycle where it dequeues.
    assign space = (count_q < CNT_W'(DEPTH));

    // Grant: scan N_IN candidates. Round-robin starts just past the last
    // winner; fixed priority starts at index 0.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (RR_MODE != 0) begin
                cand = SRC_W'((int'(rr_ptr_q) + 1 + k) % N_IN);
            end else begin
                cand = SRC_W'(k);
            end
            if (!grant_any && io_in_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        io_in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            io_in_ready[i] = space & grant_any & (grant_idx == SRC_W'(i));
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        wr_entry = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (grant_idx == SRC_W'(i)) begin
                wr_entry = {SRC_W'(i),
                            io_in_bits_tag[i*TAG_W +: TAG_W],
                            io_in_bits_way_en[i*WAY_W +: WAY_W],
                            io_in_bits_idx[i*IDX_W +: IDX_W]};
            end
        end
    end

    assign fire_in      = space & grant_any;
    assign io_out_valid = (count_q != '0);
    assign fire_out     = io_out_valid & io_out_ready;

    always_comb begin
        wr_ptr_d = fire_in  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = fire_out ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        rr_ptr_d = ((RR_MODE != 0) && fire_in) ? grant_idx : rr_ptr_q;
        case ({fire_in, fire_out})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_ptr_q <= SRC_W'(N_IN - 1);
            for (int e = 0; e < DEPTH; e++) begin
                mem_q[e] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rr_ptr_q <= rr_ptr_d;
            if (fire_in) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

    assign head = mem_q[rd_ptr_q];
    assign {io_out_bits_src, io_out_bits_tag, io_out_bits_way_en, io_out_bits_idx} = head;
    assign io_count = count_q;

endmodule

// File: tb/tb_meta_write_rr_arbiter.sv
// Bench for meta_write_rr_arbiter: a fixed-priority instance (d0) and a
// round-robin instance (d1) share all inputs; each has its own outputs.
module tb_meta_write_rr_arbiter;

  localparam int N_IN  = 8;
  localparam int IDX_W = 6;
  localparam int WAY_W = 8;
  localparam int TAG_W = 20;
  localparam int DEPTH = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N_IN-1:0]       in_valid;
  logic [N_IN*IDX_W-1:0] in_idx;
  logic [N_IN*WAY_W-1:0] in_way;
  logic [N_IN*TAG_W-1:0] in_tag;
  logic                  out_ready;

  logic [N_IN-1:0] rdy0, rdy1;
  logic            ov0, ov1;
  logic [IDX_W-1:0] idx0, idx1;
  logic [WAY_W-1:0] way0, way1;
  logic [TAG_W-1:0] tag0, tag1;
  logic [2:0]       src0, src1;
  logic [1:0]       cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  meta_write_rr_arbiter #(.N_IN(N_IN), .IDX_W(IDX_W), .WAY_W(WAY_W), .TAG_W(TAG_W),
                          .RR_MODE(0), .DEPTH(DEPTH)) d0 (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rdy0),
    .io_in_bits_idx(in_idx), .io_in_bits_way_en(in_way), .io_in_bits_tag(in_tag),
    .io_out_valid(ov0), .io_out_ready(out_ready),
    .io_out_bits_idx(idx0), .io_out_bits_way_en(way0), .io_out_bits_tag(tag0),
    .io_out_bits_src(src0), .io_count(cnt0)
  );

  meta_write_rr_arbiter #(.N_IN(N_IN), .IDX_W(IDX_W), .WAY_W(WAY_W), .TAG_W(TAG_W),
                          .RR_MODE(1), .DEPTH(DEPTH)) d1 (
    .clock(clock), .reset(reset),
    .io_in_valid(in_valid), .io_in_ready(rdy1),
    .io_in_bits_idx(in_idx), .io_in_bits_way_en(in_way), .io_in_bits_tag(in_tag),
    .io_out_valid(ov1), .io_out_ready(out_ready),
    .io_out_bits_idx(idx1), .io_out_bits_way_en(way1), .io_out_bits_tag(tag1),
    .io_out_bits_src(src1), .io_count(cnt1)
  );

  typedef struct {
    logic       rst;     // apply reset before this row
    logic [7:0] valid;
    logic       oready;
    logic [7:0] d0_rdy;
    logic [2:0] d0_src;
    logic [7:0] d1_rdy;
    logic [2:0] d1_src;
    logic       ov;
    logic [1:0] cnt;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input logic r, input logic [7:0] v, input logic o,
                              input logic [7:0] r0, input logic [2:0] s0,
                              input logic [7:0] r1, input logic [2:0] s1,
                              input logic ovv, input logic [1:0] c);
    vec_t t;
    t.rst = r; t.valid = v; t.oready = o;
    t.d0_rdy = r0; t.d0_src = s0; t.d1_rdy = r1; t.d1_src = s1;
    t.ov = ovv; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_payload(input int i, input logic [IDX_W-1:0] idx,
                             input logic [WAY_W-1:0] way, input logic [TAG_W-1:0] tag);
    in_idx[i*IDX_W +: IDX_W] = idx;
    in_way[i*WAY_W +: WAY_W] = way;
    in_tag[i*TAG_W +: TAG_W] = tag;
  endtask

  // Requester i carries idx 8+i, way_en 1<<i, tag 0x10000+i.
  task automatic default_payload();
    for (int i = 0; i < N_IN; i++) begin
      set_payload(i, IDX_W'(8 + i), WAY_W'(1 << i), TAG_W'(20'h10000 + i));
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    chk({tag, " rst d0 valid"}, 32'(ov0), 32'h0);
    chk({tag, " rst d1 valid"}, 32'(ov1), 32'h0);
    chk({tag, " rst d0 count"}, 32'(cnt0), 32'h0);
    chk({tag, " rst d1 count"}, 32'(cnt1), 32'h0);
    chk({tag, " rst d1 idx"},   32'(idx1), 32'h0);
    chk({tag, " rst d1 tag"},   32'(tag1), 32'h0);
    chk({tag, " rst d0 src"},   32'(src0), 32'h0);
    next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = '0;
    out_ready = 1'b0;
    in_idx = '0; in_way = '0; in_tag = '0;
    default_payload();

    // All 8 valid, output always ready: d0 stays on 0, d1 walks 0..7 and wraps.
    vecs[0]  = mk(1'b1, 8'hff, 1'b1, 8'h01, 3'd0, 8'h01, 3'd0, 1'b0, 2'd0);
    vecs[1]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h02, 3'd0, 1'b1, 2'd1);
    vecs[2]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h04, 3'd1, 1'b1, 2'd1);
    vecs[3]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h08, 3'd2, 1'b1, 2'd1);
    vecs[4]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h10, 3'd3, 1'b1, 2'd1);
    vecs[5]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h20, 3'd4, 1'b1, 2'd1);
    vecs[6]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h40, 3'd5, 1'b1, 2'd1);
    vecs[7]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h80, 3'd6, 1'b1, 2'd1);
    vecs[8]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h01, 3'd7, 1'b1, 2'd1);
    vecs[9]  = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h02, 3'd0, 1'b1, 2'd1);
    vecs[10] = mk(1'b0, 8'hff, 1'b1, 8'h01, 3'd0, 8'h04, 3'd1, 1'b1, 2'd1);
    // Only 2 and 5 valid: d1 alternates 2,5; then 5 drops and 2 repeats.
    vecs[11] = mk(1'b1, 8'h24, 1'b1, 8'h04, 3'd0, 8'h04, 3'd0, 1'b0, 2'd0);
    vecs[12] = mk(1'b0, 8'h24, 1'b1, 8'h04, 3'd2, 8'h20, 3'd2, 1'b1, 2'd1);
    vecs[13] = mk(1'b0, 8'h24, 1'b1, 8'h04, 3'd2, 8'h04, 3'd5, 1'b1, 2'd1);
    vecs[14] = mk(1'b0, 8'h24, 1'b1, 8'h04, 3'd2, 8'h20, 3'd2, 1'b1, 2'd1);
    vecs[15] = mk(1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 8'h04, 3'd5, 1'b1, 2'd1);
    vecs[16] = mk(1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 8'h04, 3'd2, 1'b1, 2'd1);
    vecs[17] = mk(1'b0, 8'h04, 1'b1, 8'h04, 3'd2, 8'h04, 3'd2, 1'b1, 2'd1);

    next_cycle();

    for (int r = 0; r < 18; r++) begin
      logic [IDX_W-1:0] e_idx1;
      logic [TAG_W-1:0] e_tag0;
      if (vecs[r].rst) do_reset($sformatf("v%0d", r));
      in_valid  = vecs[r].valid;
      out_ready = vecs[r].oready;
      e_idx1 = vecs[r].ov ? IDX_W'(8 + int'(vecs[r].d1_src)) : '0;
      e_tag0 = vecs[r].ov ? TAG_W'(20'h10000 + int'(vecs[r].d0_src)) : '0;
      @(negedge clock);
      chk($sformatf("v%0d d0 ready", r), 32'(rdy0), 32'(vecs[r].d0_rdy));
      chk($sformatf("v%0d d1 ready", r), 32'(rdy1), 32'(vecs[r].d1_rdy));
      chk($sformatf("v%0d d0 src", r),   32'(src0), 32'(vecs[r].d0_src));
      chk($sformatf("v%0d d1 src", r),   32'(src1), 32'(vecs[r].d1_src));
      chk($sformatf("v%0d d0 valid", r), 32'(ov0),  32'(vecs[r].ov));
      chk($sformatf("v%0d d1 valid", r), 32'(ov1),  32'(vecs[r].ov));
      chk($sformatf("v%0d d1 count", r), 32'(cnt1), 32'(vecs[r].cnt));
      chk($sformatf("v%0d d1 idx", r),   32'(idx1), 32'(e_idx1));
      chk($sformatf("v%0d d0 tag", r),   32'(tag0), 32'(e_tag0));
      next_cycle();
    end

    // Backpressure: two enqueues fill DEPTH=2, head holds, then drains in order.
    do_reset("bp");
    default_payload();
    out_ready = 1'b0;
    in_valid  = 8'h01;
    set_payload(0, 6'h11, 8'h01, 20'h00011);
    @(negedge clock);
    chk("bp c0 d0 ready", 32'(rdy0), 32'h01);
    chk("bp c0 d1 ready", 32'(rdy1), 32'h01);
    next_cycle();
    set_payload(0, 6'h22, 8'h01, 20'h00022);
    @(negedge clock);
    chk("bp c1 d0 count", 32'(cnt0), 32'h1);
    chk("bp c1 d1 head",  32'(idx1), 32'h11);
    next_cycle();
    set_payload(0, 6'h33, 8'h01, 20'h00033);
    @(negedge clock);
    chk("bp full d0 count", 32'(cnt0), 32'h2);
    chk("bp full d1 count", 32'(cnt1), 32'h2);
    chk("bp full d0 ready", 32'(rdy0), 32'h00);
    chk("bp full d1 ready", 32'(rdy1), 32'h00);
    chk("bp full d0 head",  32'(idx0), 32'h11);
    next_cycle();
    @(negedge clock);
    chk("bp hold d0 head",  32'(idx0), 32'h11);
    chk("bp hold d1 tag",   32'(tag1), 32'h00011);
    next_cycle();
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp drain0 d0 head",  32'(idx0), 32'h11);
    chk("bp drain0 d0 ready", 32'(rdy0), 32'h00);
    next_cycle();
    @(negedge clock);
    chk("bp drain1 d0 count", 32'(cnt0), 32'h1);
    chk("bp drain1 d1 count", 32'(cnt1), 32'h1);
    chk("bp drain1 d0 head",  32'(idx0), 32'h22);
    chk("bp drain1 d1 head",  32'(idx1), 32'h22);
    chk("bp drain1 d0 ready", 32'(rdy0), 32'h01);
    next_cycle();
    @(negedge clock);
    chk("bp drain2 d0 count", 32'(cnt0), 32'h1);
    chk("bp drain2 d0 head",  32'(idx0), 32'h33);
    next_cycle();

    // Simultaneous enqueue and dequeue at count=1.
    do_reset("sim");
    default_payload();
    out_ready = 1'b0;
    in_valid  = 8'h01;
    @(negedge clock);
    chk("sim c0 d0 count", 32'(cnt0), 32'h0);
    next_cycle();
    in_valid  = 8'h40;
    out_ready = 1'b1;
    set_payload(6, 6'h3f, 8'h40, 20'hABCDE);
    @(negedge clock);
    chk("sim c1 d0 count", 32'(cnt0), 32'h1);
    chk("sim c1 d0 ready", 32'(rdy0), 32'h40);
    chk("sim c1 d1 ready", 32'(rdy1), 32'h40);
    chk("sim c1 d1 src",   32'(src1), 32'h0);
    next_cycle();
    in_valid  = 8'h00;
    out_ready = 1'b0;
    @(negedge clock);
    chk("sim c2 d0 count", 32'(cnt0), 32'h1);
    chk("sim c2 d1 count", 32'(cnt1), 32'h1);
    chk("sim c2 d0 tag",   32'(tag0), 32'hABCDE);
    chk("sim c2 d1 way",   32'(way1), 32'h40);
    chk("sim c2 d1 src",   32'(src1), 32'h6);
    chk("sim c2 d0 idx",   32'(idx0), 32'h3f);
    next_cycle();

    // Reset mid-flight with count=2, then round-robin restarts at input 0.
    do_reset("mid");
    default_payload();
    out_ready = 1'b0;
    in_valid  = 8'hff;
    @(negedge clock);
    chk("mid c0 d1 ready", 32'(rdy1), 32'h01);
    next_cycle();
    @(negedge clock);
    chk("mid c1 d1 ready", 32'(rdy1), 32'h02);
    next_cycle();
    @(negedge clock);
    chk("mid full d0 count", 32'(cnt0), 32'h2);
    chk("mid full d1 count", 32'(cnt1), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    chk("mid rst d0 valid", 32'(ov0),  32'h0);
    chk("mid rst d1 valid", 32'(ov1),  32'h0);
    chk("mid rst d0 count", 32'(cnt0), 32'h0);
    chk("mid rst d1 count", 32'(cnt1), 32'h0);
    chk("mid rst d1 idx",   32'(idx1), 32'h0);
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    chk("mid rel d1 ready", 32'(rdy1), 32'h01);
    chk("mid rel d0 ready", 32'(rdy0), 32'h01);
    next_cycle();
    @(negedge clock);
    chk("mid rel+1 d1 ready", 32'(rdy1), 32'h02);
    chk("mid rel+1 d1 src",   32'(src1), 32'h0);
    chk("mid rel+1 d1 valid", 32'(ov1),  32'h1);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
